// File: rtl/fv_poly_mult.sv
// Streaming small-by-wide polynomial multiplier over Z_q[x]/(x^N +/- 1), q = 2^QW.
// Operands are loaded one coefficient per beat, multiplied in N cycles, then streamed out.
module fv_poly_mult #(
  parameter int unsigned N   = 16,
  parameter int unsigned QW  = 5,
  parameter int unsigned UW  = 1,
  parameter int unsigned NEG = 1
) (
  input  logic          clk,
  input  logic          locked,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [QW-1:0] in_a,
  input  logic [UW-1:0] in_u,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [QW-1:0] out_c,
  output logic          out_last,
  output logic          busy
);

  localparam int unsigned KW = $clog2(N);
  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_COMP = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  logic [1:0]       state;
  logic [KW-1:0]    k;
  logic [KW-1:0]    k_nx;
  logic             k_last;
  logic [QW-1:0]    rot   [N];
  logic [QW-1:0]    acc   [N];
  logic [UW-1:0]    u_mem [N];
  logic [QW+UW-1:0] u_wide;
  logic [QW-1:0]    u_ext;

  assign k_nx   = k + KW'(1);
  assign k_last = (k == KW'(N - 1));

  // Small operand widened to QW bits: unsigned for UW=1, two's complement otherwise.
  always_comb begin
    u_wide = '0;
    if (UW == 1) u_wide = {{QW{1'b0}}, u_mem[k]};
    else         u_wide = {{QW{u_mem[k][UW-1]}}, u_mem[k]};
    u_ext = u_wide[QW-1:0];
  end

  // Operand storage: rot holds a[] and is rotated each COMP cycle so that
  // rot[i] == s(i,j)*a[(i-j) mod N] during cycle j.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (state == S_LOAD && in_valid) begin
        rot[k]   <= in_a;
        u_mem[k] <= in_u;
      end else if (state == S_COMP) begin
        for (int unsigned i = 1; i < N; i++) rot[i] <= rot[i-1];
        rot[0] <= (NEG != 0) ? ('0 - rot[N-1]) : rot[N-1];
      end
    end
  end

  always_ff @(posedge clk or negedge locked) begin
    if (!locked) begin
      state     <= S_LOAD;
      k         <= '0;
      for (int unsigned i = 0; i < N; i++) acc[i] <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_c     <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else if (flush) begin
      state     <= S_LOAD;
      k         <= '0;
      for (int unsigned i = 0; i < N; i++) acc[i] <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_c     <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (in_valid) begin
            if (k_last) begin
              k        <= '0;
              state    <= S_COMP;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end else begin
              k <= k_nx;
            end
          end
        end
        S_COMP: begin
          for (int unsigned i = 0; i < N; i++) acc[i] <= acc[i] + rot[i] * u_ext;
          if (k_last) begin
            k     <= '0;
            state <= S_OUT;
          end else begin
            k <= k_nx;
          end
        end
        S_OUT: begin
          // First OUT cycle primes the registered output from acc[0].
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_c     <= acc[0];
            out_last  <= 1'b0;
          end else if (out_ready) begin
            if (k_last) begin
              state     <= S_LOAD;
              k         <= '0;
              for (int unsigned i = 0; i < N; i++) acc[i] <= '0;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              out_c     <= '0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
            end else begin
              k        <= k_nx;
              out_c    <= acc[k_nx];
              out_last <= (k_nx == KW'(N - 1));
            end
          end
        end
        default: begin
          state    <= S_LOAD;
          k        <= '0;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fv_poly_mult.md
FV_POLY_MULT -- requirements
Module: fv_poly_mult

Interface
- REQ-001: Parameter N, default 16: polynomial length (coefficient count); power of two, N >= 2.
- REQ-002: Parameter QW, default 5: coefficient width; modulus q = 2^QW.
- REQ-003: Parameter UW, default 1: small-operand width; UW=1 unsigned {0,1}, UW>=2 signed two's complement.
- REQ-004: Parameter NEG, default 1: 1 = negacyclic ring Z_q[x]/(x^N+1), 0 = cyclic Z_q[x]/(x^N-1).
- REQ-005: clk  in  1  single system clock, rising edge.
- REQ-006: locked  in  1  reset, asynchronous, active-low (PLL locked; 0 holds block in reset).
- REQ-007: flush  in  1  synchronous abort; discards operands and results.
- REQ-008: in_valid  in  1  operand beat valid.
- REQ-009: in_ready  out  1  block accepts operand beat.
- REQ-010: in_a  in  QW  coefficient a[k] of the wide operand, k = 0 first.
- REQ-011: in_u  in  UW  coefficient u[k] of the small operand, same beat as in_a.
- REQ-012: out_valid  out  1  result beat valid.
- REQ-013: out_ready  in  1  downstream accepts result beat.
- REQ-014: out_c  out  QW  result coefficient c[k], k = 0 first.
- REQ-015: out_last  out  1  high with c[N-1].
- REQ-016: busy  out  1  high in COMP and OUT states.

Function
- REQ-017: The block SHALL compute c = a*u in the ring selected by NEG, all arithmetic mod 2^QW (natural QW-bit wrap).
- REQ-018: c[i] SHALL equal sum over j of s(i,j)*a[(i-j) mod N]*u[j]; s = -1 when NEG=1 and i-j < 0, else +1.
- REQ-019: FSM states: LOAD, COMP, OUT; every output registered.
- REQ-020: LOAD: in_ready=1; each in_valid&in_ready beat stores a[k], u[k] and increments k; the beat with k=N-1 moves to COMP.
- REQ-021: COMP: exactly N cycles; cycle j adds rot[i]*u[j] to acc[i] for all i in parallel, then rotates rot up by one position, the wrapped element negated mod q when NEG=1.
- REQ-022: Last input beat accepted on edge t -> in_ready low from t+1; out_valid first high after edge t+N+1.
- REQ-023: OUT: out_valid=1, out_c=c[k]; k advances only on out_valid&out_ready; out_c and out_last SHALL hold while out_ready=0.
- REQ-024: The handshake on c[N-1] SHALL return to LOAD with k=0, acc cleared, in_ready=1 on the next cycle.
- REQ-025: in_valid outside LOAD SHALL be ignored; out_ready outside OUT SHALL be ignored.
- REQ-026: flush SHALL take priority over any handshake in the same cycle; next state is LOAD, k=0, acc cleared, out_valid=0, in_ready=1; it SHALL be legal in every state.
- REQ-027: u values SHALL be sign-extended for UW>=2 (e.g. UW=2 code 2'b11 = -1, 2'b10 = -2) and zero-extended for UW=1.

Reset
- REQ-028: While locked=0: state LOAD, k=0, acc=0, in_ready=1, out_valid=0, out_c=0, out_last=0, busy=0.
- REQ-029: Deassertion of locked mid-COMP or mid-OUT SHALL leave the block in LOAD with no stale result emitted.

Verification (N=4, QW=5)
- REQ-030: UW=1, NEG=1, a=[1,2,3,4], u=[0,1,0,0] -> c=[28,1,2,3], out_last on 4th beat, out_valid exactly 5 cycles after last input edge.
- REQ-031: UW=1, NEG=0, same operands -> c=[4,1,2,3].
- REQ-032: UW=2, NEG=1, a=[1,2,3,4], u=[3,0,0,0] (u0=-1) -> c=[31,30,29,28].
- REQ-033: UW=1, NEG=1, a=[31,31,31,31], u=[1,1,1,1] -> c=[2,0,30,28] (wrap check); out_ready toggled 1,0,0,1,... -> each c held stable, none skipped or duplicated.
- REQ-034: flush asserted after 2 input beats, then a full new operand pair -> only the new product emitted; flush on the same cycle as the final out handshake -> LOAD, no extra beat.
- REQ-035: locked pulled low during COMP cycle 2 -> all outputs at reset values; after release a fresh load produces a correct product.
